// File: rtl/inst_fetch_mem_pkg.sv
// Shared constants for the instruction fetch memory: default fault word and the
// response-slot state encoding.
package inst_fetch_mem_pkg;

   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one registered read port.
// Contents are never reset.
module imem_array #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read data only changes on a read, so a held response stays stable.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: valid/ready request in, one-cycle registered response out,
// with alignment/range fault decode and a program-load write port.
module inst_fetch_mem
   import inst_fetch_mem_pkg::*;
#(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 32,
   parameter logic [31:0]       BASE_ADDR = 32'h0,
   parameter logic [DATA_W-1:0] NOP_WORD  = NOP_WORD_DEF
) (
   input  logic                     Clk,
   input  logic                     Clrn,
   input  logic                     ReqValid,
   output logic                     ReqReady,
   input  logic [31:0]              Addr,
   output logic                     RspValid,
   input  logic                     RspReady,
   output logic [DATA_W-1:0]        Inst,
   output logic                     Fault,
   input  logic                     LdEn,
   input  logic [$clog2(DEPTH)-1:0] LdAddr,
   input  logic [DATA_W-1:0]        LdData
);

   localparam int unsigned AW          = $clog2(DEPTH);
   localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic              fault_q;
   logic              fault_d;
   logic              full;
   logic              accept;
   logic [32:0]       offset;
   logic [AW-1:0]     word_idx;
   logic [DATA_W-1:0] rd_data;
   logic              unused_offset_lsb;

   // Extra top bit is the borrow: set when Addr lies below BASE_ADDR.
   assign offset            = {1'b0, Addr} - {1'b0, BASE_ADDR};
   assign word_idx          = offset[AW+1:2];
   assign unused_offset_lsb = ^offset[1:0];
   assign fault_d           = (Addr[1:0] != 2'b00) | offset[32] | (offset[31:2] >= DEPTH_WORDS);

   assign full     = (state_q == FULL);
   assign ReqReady = (!full | RspReady) & !LdEn;
   assign accept   = ReqValid & ReqReady;

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_imem (
      .clk   (Clk),
      .we    (LdEn),
      .waddr (LdAddr),
      .wdata (LdData),
      .re    (accept & !fault_d),
      .raddr (word_idx),
      .rdata (rd_data)
   );

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         fault_q <= 1'b0;
      end else if (accept) begin
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (!accept && RspReady) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      RspValid = full;
      Fault    = full & fault_q;
      Inst     = NOP_WORD;
      if (full && !fault_q) begin
         Inst = rd_data;
      end
   end

endmodule

// File: doc/inst_fetch_mem.md
INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of words; power of two, 2..4096.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, meaning byte address of word 0.
REQ-004 SHALL have parameter NOP_WORD, default 32'h0, meaning word returned on fault.
REQ-005 SHALL have port Clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port Clrn, input, 1, meaning reset; asynchronous and active-low.
REQ-007 SHALL have port ReqValid, input, 1, meaning a fetch request is present.
REQ-008 SHALL have port ReqReady, output, 1, meaning the block accepts a request this cycle.
REQ-009 SHALL have port Addr, input, 32, meaning fetch byte address.
REQ-010 SHALL have port RspValid, output, 1, meaning Inst is valid.
REQ-011 SHALL have port RspReady, input, 1, meaning the consumer accepts the response.
REQ-012 SHALL have port Inst, output, DATA_W, meaning fetched instruction.
REQ-013 SHALL have port Fault, output, 1, meaning the response is misaligned or out of range; qualified by RspValid.
REQ-014 SHALL have port LdEn, input, 1, meaning program-load write strobe.
REQ-015 SHALL have port LdAddr, input, clog2(DEPTH), meaning load word index.
REQ-016 SHALL have port LdData, input, DATA_W, meaning load word.

Function
REQ-017 A request SHALL be accepted on a rising edge where ReqValid and ReqReady are both 1.
REQ-018 ReqReady SHALL be (!RspValid | RspReady) & !LdEn, evaluated combinationally.
REQ-019 The response SHALL appear with RspValid=1 exactly one cycle after acceptance; latency is 1.
REQ-020 While RspValid=1 and RspReady=0, Inst, Fault and RspValid SHALL hold stable.
REQ-021 Accept and retire in the same cycle SHALL give back-to-back responses, one per cycle, with no bubble.
REQ-022 RspValid SHALL fall on a retire edge with no accept.
REQ-023 Word index SHALL be (Addr - BASE_ADDR) >> 2, truncated to clog2(DEPTH) bits.
REQ-024 Fault SHALL be 1 if Addr[1:0] != 0, or if (Addr - BASE_ADDR) >> 2 >= DEPTH (unsigned, no wrap-around).
REQ-025 When Fault=1, Inst SHALL equal NOP_WORD.
REQ-026 An LdEn=1 edge SHALL write LdData to word LdAddr; ReqReady=0 blocks any fetch accept in that cycle.
REQ-027 A response already held SHALL be unaffected by a later load to the same word.
REQ-028 A fetch accepted on the cycle after a load to the same word SHALL return the new data.
REQ-029 The control state SHALL be EMPTY (RspValid=0) or FULL (RspValid=1):
  - EMPTY to FULL on accept.
  - FULL to FULL on accept.
  - FULL to EMPTY on retire without accept.

Reset
REQ-030 Clrn=0 SHALL immediately force RspValid=0, Inst=NOP_WORD, Fault=0 and state EMPTY, regardless of the clock.
REQ-031 Reset SHALL NOT clear array contents; a reset during a held response SHALL drop that response.
REQ-032 The first accept SHALL be possible on the first rising edge after Clrn deasserts.

Structure
REQ-033 The shared package SHALL hold NOP_WORD default and the state encoding constants EMPTY and FULL.
REQ-034 The storage array SHALL be the one sub-module, imem_array, with one synchronous write port and one synchronous read port.
REQ-035 Handshake, fault decode and output registers SHALL stay in inst_fetch_mem.

Verification
REQ-036 Load and fetch:
  - Stimulus: load words 0..3 = 8C010018, 8C020014, 00221820, 00222022; fetch 0,4,8,C with RspReady=1.
  - Response: same four words on consecutive cycles, Fault=0.
REQ-037 Backpressure:
  - Stimulus: RspReady=0 for 3 cycles with the response to Addr=4 pending.
  - Response: Inst=8C020014 stable; ReqReady=0; no request lost.
REQ-038 Faults:
  - Stimulus: Addr=6, then Addr=0x80 with DEPTH=32.
  - Response: Fault=1, Inst=NOP_WORD for each.
REQ-039 Load hazard:
  - Stimulus: LdEn=1 with ReqValid=1; then fetch the same word.
  - Response: ReqReady=0 during the load; the fetch returns the new data.
REQ-040 Reset mid-stall:
  - Stimulus: Clrn=0 between clock edges while RspValid=1.
  - Response: RspValid=0 immediately; array data retained on the next fetch.
REQ-041 Parametrisation:
  - Stimulus: DEPTH=1024, BASE_ADDR=0x400; fetch 0x400 and 0x13FC, then 0x1400.
  - Response: 0x400 returns word 0 and 0x13FC returns word 1023; 0x1400 gives Fault=1.
